// File: rtl/sfp_los_debounce.sv
// Synchronises and debounces per-channel SFP LOS pins, with sticky change flags and an event pulse.
// Optional per-channel 8-bit transition counters are built only when SFP_LOS_CHANGE_CNT_EN is defined.
module sfp_los_debounce #(
  parameter int pNUM_CH      = 24,
  parameter int pSYNC_STAGES = 2
) (
  input  logic                   iCLK_100M,
  input  logic                   iRST_100M_n,
  input  logic [pNUM_CH-1:0]     iSFP_LOS_RAW,
  input  logic [15:0]            iREG_LOS_DEBOUNCE_CYCLES,
  input  logic [pNUM_CH-1:0]     iREG_LOS_CHANGE_CLR,
  output logic [pNUM_CH-1:0]     oSFP_LOS,
  output logic [pNUM_CH-1:0]     oLOS_CHANGE,
  output logic                   oLOS_EVENT,
  output logic [8*pNUM_CH-1:0]   oLOS_CHANGE_CNT
);

  logic [pNUM_CH-1:0] sync_q [pSYNC_STAGES];
  logic [pNUM_CH-1:0] syn;
  logic [pNUM_CH-1:0] tgl;
  logic [16:0]        thr;
  logic               tgl_any_q;

  // Synchronizer resets to "signal lost" so an unplugged port never looks up.
  always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
    if (!iRST_100M_n) begin
      for (int s = 0; s < pSYNC_STAGES; s++) begin
        sync_q[s] <= '1;
      end
    end else begin
      sync_q[0] <= iSFP_LOS_RAW;
      for (int s = 1; s < pSYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign syn = sync_q[pSYNC_STAGES-1];

  // A zero threshold is treated as one; 17 bits keep cnt+1 from wrapping at 16'hFFFF.
  assign thr = (iREG_LOS_DEBOUNCE_CYCLES == 16'd0) ? 17'd1 : {1'b0, iREG_LOS_DEBOUNCE_CYCLES};

  for (genvar n = 0; n < pNUM_CH; n++) begin : g_ch
    logic [15:0] cnt_q;
    logic [16:0] cnt_inc;
    logic        differ;

    assign cnt_inc = {1'b0, cnt_q} + 17'd1;
    assign differ  = syn[n] ^ oSFP_LOS[n];
    assign tgl[n]  = differ && (cnt_inc >= thr);

    always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
      if (!iRST_100M_n) begin
        cnt_q       <= 16'd0;
        oSFP_LOS[n] <= 1'b1;
      end else if (!differ || tgl[n]) begin
        cnt_q <= 16'd0;
        if (tgl[n]) begin
          oSFP_LOS[n] <= syn[n];
        end
      end else begin
        cnt_q <= cnt_inc[15:0];
      end
    end

    // Set beats clear so a toggle landing on a clear strobe is never lost.
    always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
      if (!iRST_100M_n) begin
        oLOS_CHANGE[n] <= 1'b0;
      end else if (tgl[n]) begin
        oLOS_CHANGE[n] <= 1'b1;
      end else if (iREG_LOS_CHANGE_CLR[n]) begin
        oLOS_CHANGE[n] <= 1'b0;
      end
    end

`ifdef SFP_LOS_CHANGE_CNT_EN
    logic [7:0] tcnt_q;

    always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
      if (!iRST_100M_n) begin
        tcnt_q <= 8'd0;
      end else if (tgl[n]) begin
        if (iREG_LOS_CHANGE_CLR[n]) begin
          tcnt_q <= 8'd1;
        end else if (tcnt_q != 8'hFF) begin
          tcnt_q <= tcnt_q + 8'd1;
        end
      end else if (iREG_LOS_CHANGE_CLR[n]) begin
        tcnt_q <= 8'd0;
      end
    end

    assign oLOS_CHANGE_CNT[8*n +: 8] = tcnt_q;
`endif
  end

`ifndef SFP_LOS_CHANGE_CNT_EN
  assign oLOS_CHANGE_CNT = '0;
`endif

  // Event fires the cycle after the new oSFP_LOS value becomes visible.
  always_ff @(posedge iCLK_100M or negedge iRST_100M_n) begin
    if (!iRST_100M_n) begin
      tgl_any_q  <= 1'b0;
      oLOS_EVENT <= 1'b0;
    end else begin
      tgl_any_q  <= |tgl;
      oLOS_EVENT <= tgl_any_q;
    end
  end

endmodule

// File: tb/tb_sfp_los_debounce.sv
// Directed bench for sfp_los_debounce: per-cycle vector table plus hand sequences for threshold, reset and counter cases.
module tb_sfp_los_debounce;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [23:0]  raw = 24'hFFFFFF;
  logic [15:0]  thr = 16'd4;
  logic [23:0]  clr = 24'h0;
  logic [23:0]  los;
  logic [23:0]  chg;
  logic         ev;
  logic [191:0] cnt_out;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [23:0] raw;
    logic [23:0] clr;
    logic [15:0] thr;
    logic [23:0] los;
    logic [23:0] chg;
    logic        ev;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  sfp_los_debounce #(.pNUM_CH(24), .pSYNC_STAGES(2)) dut (
    .iCLK_100M                (clk),
    .iRST_100M_n              (rst_n),
    .iSFP_LOS_RAW             (raw),
    .iREG_LOS_DEBOUNCE_CYCLES (thr),
    .iREG_LOS_CHANGE_CLR      (clr),
    .oSFP_LOS                 (los),
    .oLOS_CHANGE              (chg),
    .oLOS_EVENT               (ev),
    .oLOS_CHANGE_CNT          (cnt_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [23:0] r, input logic [23:0] c, input logic [15:0] t,
                     input logic [23:0] l, input logic [23:0] g, input logic e);
    vec_t v;
    v.raw = r; v.clr = c; v.thr = t; v.los = l; v.chg = g; v.ev = e;
    tbl.push_back(v);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset release with all raw=1: everything lost, no change, no event.
    for (int i = 0; i < 3; i++) add(24'hFFFFFF, 24'h0, 16'd4, 24'hFFFFFF, 24'h0, 1'b0);
    // ch3 1->0 step: output at edge 6, event at edge 7.
    for (int i = 0; i < 5; i++) add(24'hFFFFF7, 24'h0, 16'd4, 24'hFFFFFF, 24'h0, 1'b0);
    add(24'hFFFFF7, 24'h0, 16'd4, 24'hFFFFF7, 24'h8, 1'b0);
    add(24'hFFFFF7, 24'h0, 16'd4, 24'hFFFFF7, 24'h8, 1'b1);
    add(24'hFFFFF7, 24'h0, 16'd4, 24'hFFFFF7, 24'h8, 1'b0);
    add(24'hFFFFF7, 24'h0, 16'd4, 24'hFFFFF7, 24'h8, 1'b0);
    // Isolated clear of ch3.
    add(24'hFFFFF7, 24'h8, 16'd4, 24'hFFFFF7, 24'h0, 1'b0);
    add(24'hFFFFF7, 24'h0, 16'd4, 24'hFFFFF7, 24'h0, 1'b0);
    // Two 3-cycle glitches on ch5 separated by 2 cycles: count must restart.
    for (int i = 0; i < 3; i++) add(24'hFFFFD7, 24'h0, 16'd4, 24'hFFFFF7, 24'h0, 1'b0);
    for (int i = 0; i < 2; i++) add(24'hFFFFF7, 24'h0, 16'd4, 24'hFFFFF7, 24'h0, 1'b0);
    for (int i = 0; i < 3; i++) add(24'hFFFFD7, 24'h0, 16'd4, 24'hFFFFF7, 24'h0, 1'b0);
    for (int i = 0; i < 6; i++) add(24'hFFFFF7, 24'h0, 16'd4, 24'hFFFFF7, 24'h0, 1'b0);
    // ch3 0->1 with a clear on the toggle edge: set wins.
    for (int i = 0; i < 5; i++) add(24'hFFFFFF, 24'h0, 16'd4, 24'hFFFFF7, 24'h0, 1'b0);
    add(24'hFFFFFF, 24'h8, 16'd4, 24'hFFFFFF, 24'h8, 1'b0);
    add(24'hFFFFFF, 24'h0, 16'd4, 24'hFFFFFF, 24'h8, 1'b1);
    add(24'hFFFFFF, 24'h0, 16'd4, 24'hFFFFFF, 24'h8, 1'b0);
    add(24'hFFFFFF, 24'h8, 16'd4, 24'hFFFFFF, 24'h0, 1'b0);
    add(24'hFFFFFF, 24'h0, 16'd4, 24'hFFFFFF, 24'h0, 1'b0);
    // ch0 and ch1 toggle together: both flags, a single event pulse.
    for (int i = 0; i < 5; i++) add(24'hFFFFFC, 24'h0, 16'd4, 24'hFFFFFF, 24'h0, 1'b0);
    add(24'hFFFFFC, 24'h0, 16'd4, 24'hFFFFFC, 24'h3, 1'b0);
    add(24'hFFFFFC, 24'h0, 16'd4, 24'hFFFFFC, 24'h3, 1'b1);
    add(24'hFFFFFC, 24'h0, 16'd4, 24'hFFFFFC, 24'h3, 1'b0);
    add(24'hFFFFFC, 24'h0, 16'd4, 24'hFFFFFC, 24'h3, 1'b0);

    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst los", los, 24'hFFFFFF);
    chk("rst chg", chg, 24'h0);
    chk("rst ev", ev, 1'b0);
    chk("rst cnt", cnt_out, 192'h0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      raw = tbl[i].raw;
      clr = tbl[i].clr;
      thr = tbl[i].thr;
      tick();
      chk($sformatf("vec%0d los", i), los, tbl[i].los);
      chk($sformatf("vec%0d chg", i), chg, tbl[i].chg);
      chk($sformatf("vec%0d ev", i), ev, tbl[i].ev);
    end

    // Threshold 0 acts as 1: ch7 output 3 edges after the step.
    raw = 24'hFFFF7C;
    thr = 16'd0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk($sformatf("thr0 edge%0d los7", k), los[7], (k < 3) ? 1'b1 : 1'b0);
    end

    // Threshold lowered from 100 to 10 while ch8 count is 50.
    raw = 24'hFFFE7C;
    thr = 16'd100;
    repeat (52) tick();
    chk("thr100 cnt50 los8", los[8], 1'b1);
    thr = 16'd10;
    tick();
    chk("thr10 los8", los[8], 1'b0);
    tick();
    chk("thr10 ev", ev, 1'b1);

    // Reset mid-count on ch9 discards the partial count.
    thr = 16'd4;
    raw = 24'hFFFC7C;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst los", los, 24'hFFFFFF);
    chk("midrst chg", chg, 24'h0);
    chk("midrst ev", ev, 1'b0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("postrst edge%0d los9", k), los[9], (k < 6) ? 1'b1 : 1'b0);
      chk($sformatf("postrst edge%0d chg", k), chg, (k < 6) ? 24'h0 : 24'h000383);
      chk($sformatf("postrst edge%0d ev", k), ev, 1'b0);
    end

`ifdef SFP_LOS_CHANGE_CNT_EN
    thr = 16'd1;
    clr = 24'hFFFFFF;
    tick();
    clr = 24'h0;
    chk("cnt clr all", cnt_out[7:0], 8'h00);
    chk("chg clr all", chg, 24'h0);
    for (int t = 0; t < 5; t++) begin
      raw[0] = ~raw[0];
      repeat (4) tick();
    end
    chk("cnt0 after 5", cnt_out[7:0], 8'd5);
    chk("cnt1 untouched", cnt_out[15:8], 8'd0);
    raw[0] = ~raw[0];
    repeat (2) tick();
    clr = 24'h1;
    tick();
    clr = 24'h0;
    chk("cnt0 tgl+clr", cnt_out[7:0], 8'd1);
    chk("chg0 tgl+clr", chg[0], 1'b1);
    for (int t = 0; t < 300; t++) begin
      raw[0] = ~raw[0];
      tick();
    end
    repeat (4) tick();
    chk("cnt0 saturate", cnt_out[7:0], 8'hFF);
    clr = 24'h1;
    tick();
    clr = 24'h0;
    chk("cnt0 after clr", cnt_out[7:0], 8'h00);
    chk("chg0 after clr", chg[0], 1'b0);
`else
    chk("cnt tied 0", cnt_out, 192'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfp_los_debounce.md
SFP_LOS_DEBOUNCE -- requirements
Module: sfp_los_debounce

Interface
REQ-001 Parameter pNUM_CH, default 24: number of SFP loss-of-signal channels, legal range 1..24.
REQ-002 Parameter pSYNC_STAGES, default 2: metastability synchronizer depth per channel, legal range 2..4.
REQ-003 iCLK_100M  input  1: the only clock; every flop in the block is on it.
REQ-004 iRST_100M_n  input  1: asynchronous assert, active-low reset (already decided).
REQ-005 iSFP_LOS_RAW  input  pNUM_CH: raw LOS pins, asynchronous to iCLK_100M; 1 = signal lost.
REQ-006 iREG_LOS_DEBOUNCE_CYCLES  input  16: number of consecutive stable cycles required before the output changes; quasi-static register value.
REQ-007 iREG_LOS_CHANGE_CLR  input  pNUM_CH: single-cycle clear strobes for the sticky change flags, one bit per channel.
REQ-008 oSFP_LOS  output  pNUM_CH: debounced LOS, registered; drives iSFP_LOS of chipregs_wrap.
REQ-009 oLOS_CHANGE  output  pNUM_CH: sticky per-channel flag; 1 = debounced LOS toggled since the last clear.
REQ-010 oLOS_EVENT  output  1: single-cycle pulse in the cycle after any channel's oSFP_LOS toggles.
REQ-011 oLOS_CHANGE_CNT  output  8*pNUM_CH: per-channel transition counts; channel n occupies bits [8n+7:8n].

Function
REQ-012 Each raw bit shall pass through pSYNC_STAGES flops before any other logic uses it; the synchronizer output is called syn[n].
REQ-013 Each channel shall own a 16-bit stability counter cnt[n].
REQ-014 When syn[n] equals oSFP_LOS[n], cnt[n] shall clear to 0 on the next edge.
REQ-015 When syn[n] differs from oSFP_LOS[n] and cnt[n]+1 < thr, cnt[n] shall increment, where thr = max(iREG_LOS_DEBOUNCE_CYCLES, 1).
REQ-016 When syn[n] differs from oSFP_LOS[n] and cnt[n]+1 >= thr, oSFP_LOS[n] shall take syn[n] on that edge and cnt[n] shall clear.
REQ-017 A step held on iSFP_LOS_RAW[n] shall reach oSFP_LOS[n] exactly pSYNC_STAGES+thr edges after the first edge that samples it.
REQ-018 Glitches shorter than thr cycles at syn[n] shall not change oSFP_LOS[n].
REQ-019 cnt[n] shall never exceed 16'hFFFF; the arithmetic in REQ-015/016 shall be 17-bit so thr = 16'hFFFF works without wrap.
REQ-020 A change of iREG_LOS_DEBOUNCE_CYCLES mid-count shall apply on the next edge; if cnt[n]+1 >= new thr, the output shall update on that edge.
REQ-021 oLOS_CHANGE[n] shall set on any edge where oSFP_LOS[n] toggles.
REQ-022 oLOS_CHANGE[n] shall clear when iREG_LOS_CHANGE_CLR[n]=1; when a set and a clear occur in the same cycle, the set shall win.
REQ-023 oLOS_EVENT shall be the registered OR of all per-channel toggle strobes, one cycle after the oSFP_LOS update.
REQ-024 Channels shall be fully independent; simultaneous toggles on several channels shall each set their own flag and produce one oLOS_EVENT pulse.

Reset
REQ-025 On iRST_100M_n low, synchronizer flops and oSFP_LOS shall go to all-ones (signal lost).
REQ-026 On iRST_100M_n low, cnt, oLOS_CHANGE, oLOS_EVENT and oLOS_CHANGE_CNT shall go to 0.
REQ-027 A reset asserted mid-count shall discard partial counts; after release, the first toggle requires a full pSYNC_STAGES+thr cycles.
REQ-028 The reset-to-ones value of oSFP_LOS shall not set oLOS_CHANGE or pulse oLOS_EVENT.

Configuration
REQ-029 Macro SFP_LOS_CHANGE_CNT_EN defined: each channel shall keep an 8-bit saturating counter, incremented on every oSFP_LOS toggle, holding at 8'hFF, and cleared together with oLOS_CHANGE[n] by iREG_LOS_CHANGE_CLR[n].
REQ-030 With SFP_LOS_CHANGE_CNT_EN defined, a simultaneous toggle and clear shall leave the counter at 1.
REQ-031 Macro SFP_LOS_CHANGE_CNT_EN undefined: oLOS_CHANGE_CNT shall be tied to 0 and no counter flops shall be built.

Verification
REQ-032 Reset release with all raw=1 and thr=4 -> oSFP_LOS=all-ones, oLOS_CHANGE=0, no oLOS_EVENT pulse.
REQ-033 ch3 raw 1->0 held, thr=4, pSYNC_STAGES=2 -> oSFP_LOS[3]=0 exactly 6 edges later; oLOS_CHANGE[3]=1; oLOS_EVENT pulses once, one cycle after the update.
REQ-034 ch5 raw pulse of 3 cycles with thr=4 -> oSFP_LOS[5] unchanged; cnt[5] returns to 0.
REQ-035 iREG_LOS_CHANGE_CLR[3] pulsed in the same cycle as a new toggle on ch3 -> oLOS_CHANGE[3] stays 1; an isolated clear -> oLOS_CHANGE[3]=0.
REQ-036 thr set to 0 -> behaves as thr=1 (output 3 edges after raw step); thr changed from 100 to 10 while cnt=50 -> output updates on the next edge.
REQ-037 With SFP_LOS_CHANGE_CNT_EN defined: 300 toggles on ch0 -> oLOS_CHANGE_CNT[7:0]=8'hFF; after a clear -> 0.
